// File: rtl/pipeline_acc_pkg.sv
// Shared types and helpers for the pipeline_acc packet reducer.
package pipeline_acc_pkg;

  typedef enum logic {
    MODE_SUM = 1'b0,
    MODE_MAX = 1'b1
  } mode_e;

  localparam int unsigned CLAMP_W = 128;

  // Output record at the default parameterisation (PORTS=4, DATA_W=32, BEATS=4, ID_W=8)
  typedef struct packed {
    logic [35:0] data;
    logic [2:0]  beats;
    mode_e       mode;
    logic [7:0]  id;
    logic        sat;
  } rec_t;

  // Clamp v into the signed range of w bits; sat flags that the value changed.
  function automatic logic signed [CLAMP_W-1:0] sat_clamp(
    input  logic signed [CLAMP_W-1:0] v,
    input  int unsigned               w,
    output logic                      sat
  );
    logic signed [CLAMP_W-1:0] hi;
    logic signed [CLAMP_W-1:0] lo;
    hi = signed'((CLAMP_W'(1) << (w - 1)) - CLAMP_W'(1));
    lo = ~hi;
    sat = 1'b0;
    sat_clamp = v;
    if (v > hi) begin
      sat_clamp = hi;
      sat = 1'b1;
    end else if (v < lo) begin
      sat_clamp = lo;
      sat = 1'b1;
    end
  endfunction

endpackage

// File: rtl/pipeline_acc_fifo.sv
// Synchronous FIFO of output records with occupancy count.
module pipeline_acc_fifo
  import pipeline_acc_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = rec_t
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  T                             push_rec,
  input  logic                         pop,
  output T                             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T           mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= push_rec;
        wp      <= wp + AW'(1);
      end
      if (do_pop) rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_acc.sv
// Handshaked packet reducer: lane reduce, packet accumulate, clamp, credit-gated output FIFO.
module pipeline_acc
  import pipeline_acc_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_W     = 32,
  parameter int BEATS      = 4,
  parameter int OUT_W      = DATA_W + $clog2(PORTS * BEATS),
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PORTS*DATA_W-1:0]      in_data,
  input  logic                         in_last,
  input  logic                         in_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic [$clog2(BEATS+1)-1:0]   out_beats,
  output logic                         out_mode,
  output logic [ID_W-1:0]              out_id,
  output logic                         out_sat
);

  localparam int RED_W = DATA_W + $clog2(PORTS);
  localparam int ACC_W = DATA_W + $clog2(PORTS * BEATS);
  localparam int BW    = $clog2(BEATS + 1);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [BW-1:0]    beats;
    mode_e            mode;
    logic [ID_W-1:0]  id;
    logic             sat;
  } out_rec_t;

  logic                    run;
  logic [BW-1:0]           cnt;
  mode_e                   mode_lat;
  mode_e                   beat_mode;
  logic                    accept;
  logic                    first;
  logic                    close;
  logic signed [RED_W-1:0] red;
  logic signed [RED_W-1:0] lane;

  logic                    s1_valid;
  logic                    s1_first;
  logic                    s1_close;
  logic [BW-1:0]           s1_beats;
  mode_e                   s1_mode;
  logic signed [RED_W-1:0] s1_red;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] s1_ext;
  logic [OUT_W-1:0]        clamped;
  logic                    clamp_sat;
  logic [ID_W-1:0]         id_cnt;
  logic                    push;
  out_rec_t                push_rec;
  out_rec_t                head;
  logic [CW-1:0]           fifo_count;
  logic [CW:0]             credits;

  assign first     = (cnt == '0);
  assign beat_mode = first ? mode_e'(in_mode) : mode_lat;
  assign accept    = in_valid && in_ready;
  assign close     = (cnt == BW'(BEATS - 1)) || in_last;

  // A closing beat in stage 1 has already claimed a FIFO slot, so pushes never see a full FIFO.
  assign credits  = {1'b0, fifo_count} + (CW+1)'(s1_valid && s1_close);
  assign in_ready = run && (credits < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    red  = RED_W'(signed'(in_data[DATA_W-1:0]));
    lane = '0;
    for (int unsigned k = 1; k < PORTS; k++) begin
      lane = RED_W'(signed'(in_data[k*DATA_W +: DATA_W]));
      if (beat_mode == MODE_SUM) red = red + lane;
      else if (lane > red)       red = lane;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      cnt      <= '0;
      mode_lat <= MODE_SUM;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_close <= 1'b0;
      s1_beats <= '0;
      s1_mode  <= MODE_SUM;
      s1_red   <= '0;
    end else begin
      run      <= 1'b1;
      s1_valid <= accept;
      if (accept) begin
        s1_red   <= red;
        s1_first <= first;
        s1_close <= close;
        s1_beats <= cnt + BW'(1);
        s1_mode  <= beat_mode;
        if (first) mode_lat <= beat_mode;
        cnt <= close ? '0 : cnt + BW'(1);
      end
    end
  end

  // The packet result is taken straight from acc_next so the FIFO write doubles as stage 2.
  always_comb begin
    s1_ext   = ACC_W'(s1_red);
    acc_next = s1_ext;
    if (!s1_first) begin
      if (s1_mode == MODE_SUM)   acc_next = acc + s1_ext;
      else if (acc > s1_ext)     acc_next = acc;
    end
    clamp_sat = 1'b0;
    clamped   = OUT_W'(sat_clamp(CLAMP_W'(acc_next), OUT_W, clamp_sat));
  end

  assign push     = s1_valid && s1_close;
  assign push_rec = '{data:  clamped,
                      beats: s1_beats,
                      mode:  s1_mode,
                      id:    id_cnt,
                      sat:   clamp_sat && (s1_mode == MODE_SUM)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      id_cnt <= '0;
    end else begin
      if (s1_valid) acc <= acc_next;
      if (push)     id_cnt <= id_cnt + ID_W'(1);
    end
  end

  pipeline_acc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (out_rec_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_rec (push_rec),
    .pop      (out_ready),
    .head     (head),
    .count    (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_data  = head.data;
  assign out_beats = head.beats;
  assign out_mode  = head.mode;
  assign out_id    = head.id;
  assign out_sat   = head.sat;

endmodule

// File: tb/tb_pipeline_acc.sv
// Randomised self-checking bench for pipeline_acc (default width plus an 8-bit saturating copy).
module tb_pipeline_acc;

  localparam int PORTS      = 4;
  localparam int DATA_W     = 32;
  localparam int BEATS      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int ID_W       = 8;
  localparam int OUT_W      = DATA_W + $clog2(PORTS * BEATS);
  localparam int OUT_W8     = 8;
  localparam int BW         = $clog2(BEATS + 1);
  localparam int TW         = OUT_W + BW + ID_W + 2;

  logic                      clk;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_ready8;
  logic [PORTS*DATA_W-1:0]   in_data;
  logic                      in_last;
  logic                      in_mode;
  logic                      out_ready;
  logic                      out_valid;
  logic [OUT_W-1:0]          out_data;
  logic [BW-1:0]             out_beats;
  logic                      out_mode;
  logic [ID_W-1:0]           out_id;
  logic                      out_sat;
  logic                      out_valid8;
  logic [OUT_W8-1:0]         out_data8;
  logic [BW-1:0]             out_beats8;
  logic                      out_mode8;
  logic [ID_W-1:0]           out_id8;
  logic                      out_sat8;

  pipeline_acc #(
    .PORTS(PORTS), .DATA_W(DATA_W), .BEATS(BEATS), .OUT_W(OUT_W),
    .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beats(out_beats), .out_mode(out_mode), .out_id(out_id), .out_sat(out_sat)
  );

  pipeline_acc #(
    .PORTS(PORTS), .DATA_W(DATA_W), .BEATS(BEATS), .OUT_W(OUT_W8),
    .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .in_last(in_last), .in_mode(in_mode),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .out_beats(out_beats8), .out_mode(out_mode8), .out_id(out_id8), .out_sat(out_sat8)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint raw;
    int     beats;
    bit     mode;
    int     id;
  } exp_t;

  exp_t   exp_q[$];
  longint lanes_q[$];
  int     m_beats;
  bit     m_mode;
  int     m_id;
  int     checks;
  int     failures;

  function automatic longint clamp8(input longint v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic logic [PORTS*DATA_W-1:0] seq_beat(input int b);
    logic [PORTS*DATA_W-1:0] v;
    for (int k = 0; k < PORTS; k++) v[k*DATA_W +: DATA_W] = DATA_W'(b * PORTS + k + 1);
    return v;
  endfunction

  function automatic logic [PORTS*DATA_W-1:0] rand_beat();
    logic [PORTS*DATA_W-1:0] v;
    for (int k = 0; k < PORTS; k++) v[k*DATA_W +: DATA_W] = $urandom;
    return v;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    lanes_q.delete();
    m_beats = 0;
    m_id    = 0;
  endfunction

  // Packet-level reference: collect every lane, reduce the whole packet at close.
  task automatic model_beat(input logic [PORTS*DATA_W-1:0] d, input bit last, input bit mode);
    exp_t   e;
    longint r;
    logic signed [DATA_W-1:0] l;
    if (m_beats == 0) m_mode = mode;
    for (int k = 0; k < PORTS; k++) begin
      l = d[k*DATA_W +: DATA_W];
      lanes_q.push_back(longint'(l));
    end
    m_beats++;
    if (m_beats == BEATS || last) begin
      r = m_mode ? lanes_q[0] : 0;
      foreach (lanes_q[i]) begin
        if (!m_mode)          r = r + lanes_q[i];
        else if (lanes_q[i] > r) r = lanes_q[i];
      end
      e.raw = r; e.beats = m_beats; e.mode = m_mode; e.id = m_id;
      exp_q.push_back(e);
      m_id = (m_id + 1) % (1 << ID_W);
      lanes_q.delete();
      m_beats = 0;
    end
  endtask

  task automatic send_beat(input logic [PORTS*DATA_W-1:0] d, input bit last, input bit mode);
    int wait_cyc = 0;
    in_valid = 1'b1; in_data = d; in_last = last; in_mode = mode;
    while (!in_ready && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout got=0 exp=1");
    end else begin
      model_beat(d, last, mode);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic collect(input int n, input bit rand_ready);
    int   got = 0;
    int   cyc = 0;
    exp_t e;
    logic [TW-1:0] obs_v, exp_v;
    while (got < n && cyc < n * 50 + 100) begin
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got_id=%0d exp=none", out_id);
        end else begin
          e = exp_q[0];
          obs_v = {out_data, out_beats, out_mode, out_id, out_sat};
          exp_v = {OUT_W'(e.raw), BW'(e.beats), e.mode, ID_W'(e.id), 1'b0};
          if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL result got=%h exp=%h (data,beats,mode,id,sat)", obs_v, exp_v);
          end
          if (!e.mode) begin
            checks++;
            if ({out_valid8, out_data8, out_sat8} !== {1'b1, 8'(clamp8(e.raw)), clamp8(e.raw) != e.raw}) begin
              failures++;
              $display("FAIL sat8 got=%b_%h_%b exp=1_%h_%b", out_valid8, out_data8, out_sat8,
                       8'(clamp8(e.raw)), clamp8(e.raw) != e.raw);
            end
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (got < n) begin
      checks++; failures++;
      $display("FAIL collect_timeout got=%0d exp=%0d", got, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_data, out_beats, out_mode, out_id, out_sat} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {in_ready, out_valid, out_data, out_beats, out_mode, out_id, out_sat});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL ready_at_release got=%b exp=0", in_ready); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL ready_after_release got=%b exp=1", in_ready); end
    model_clear();
  endtask

  task automatic test_sum_latency();
    do_reset();
    out_ready = 1'b0;
    for (int b = 0; b < BEATS; b++) send_beat(seq_beat(b), 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL latency_t2 got=%b exp=1", out_valid); end
    checks++;
    if ({out_data, out_beats, out_mode, out_id, out_sat} !== {36'd136, 3'd4, 1'b0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL sum_136 got=%0d/%0d/%0d exp=136/4/0", out_data, out_beats, out_id);
    end
    collect(1, 1'b0);
  endtask

  task automatic test_max_early();
    do_reset();
    out_ready = 1'b0;
    send_beat({32'd3, -32'sd1, 32'd7, -32'sd5}, 1'b0, 1'b1);
    send_beat({4{-32'sd100}}, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_beats, out_mode, out_id} !== {1'b1, 36'd7, 3'd2, 1'b1, 8'd0}) begin
      failures++;
      $display("FAIL max_early got=%0d/%0d/%b exp=7/2/1", out_data, out_beats, out_mode);
    end
    collect(1, 1'b0);
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    for (int b = 0; b < BEATS; b++) send_beat({4{32'sd100}}, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({out_data8, out_sat8} !== {8'sd127, 1'b1}) begin
      failures++; $display("FAIL sat_pos got=%h/%b exp=7f/1", out_data8, out_sat8);
    end
    collect(1, 1'b0);
    for (int b = 0; b < BEATS; b++) send_beat({4{-32'sd100}}, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({out_data8, out_sat8} !== {8'h80, 1'b1}) begin
      failures++; $display("FAIL sat_neg got=%h/%b exp=80/1", out_data8, out_sat8);
    end
    collect(1, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) send_beat(rand_beat(), 1'b1, 1'($urandom_range(0, 1)));
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL credit_stop got=%b exp=0", in_ready); end
    repeat (5) @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b01) begin
      failures++; $display("FAIL credit_hold got=%b exp=01", {in_ready, out_valid});
    end
    fork
      begin
        for (int i = 0; i < 2; i++) send_beat(rand_beat(), 1'b1, 1'($urandom_range(0, 1)));
      end
      collect(6, 1'b0);
    join
  endtask

  task automatic test_gaps();
    logic [PORTS*DATA_W-1:0] beats [BEATS];
    for (int m = 0; m < 2; m++) begin
      do_reset();
      out_ready = 1'b0;
      for (int b = 0; b < BEATS; b++) beats[b] = rand_beat();
      for (int b = 0; b < BEATS; b++) send_beat(beats[b], 1'b0, 1'(m));
      collect(1, 1'b0);
      for (int b = 0; b < BEATS; b++) begin
        send_beat(beats[b], 1'b0, (b == 0) ? 1'(m) : 1'((m + b) % 2));
        repeat (3) @(negedge clk);
      end
      collect(1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) send_beat(rand_beat(), 1'b1, 1'b0);
    for (int b = 0; b < 3; b++) send_beat(rand_beat(), 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      failures++; $display("FAIL async_reset got=%b exp=00", {out_valid, in_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    for (int b = 0; b < BEATS; b++) send_beat(rand_beat(), 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({out_valid, out_id, out_beats} !== {1'b1, 8'd0, 3'd4}) begin
      failures++; $display("FAIL post_reset_id got=%b/%0d/%0d exp=1/0/4", out_valid, out_id, out_beats);
    end
    collect(1, 1'b0);
  endtask

  task automatic test_random();
    localparam int NPKT = 40;
    do_reset();
    fork
      begin
        for (int p = 0; p < NPKT; p++) begin
          int len;
          len = $urandom_range(1, BEATS);
          for (int b = 0; b < len; b++) begin
            bit last;
            last = (b == len - 1) ? ((len < BEATS) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
            send_beat(rand_beat(), last, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
          end
        end
      end
      collect(NPKT, 1'b1);
    join
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 1'b0;
    checks = 0;
    failures = 0;
    model_clear();
    test_reset();
    test_sum_latency();
    test_max_early();
    test_saturation();
    test_back_to_back();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
